// File: rtl/pe_types.sv
// Shared types for the PE accumulation path.
package pe_types;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pe_accum_state_e;

endpackage

// File: rtl/pe_sync_fifo.sv
// Synchronous FIFO with a head read straight from storage registers and an occupancy count.
// A write at full is dropped unless a pop frees a slot in the same cycle.
module pe_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_valid_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    output logic                   wr_drop_o,
    output logic                   rd_valid_o,
    output logic [WIDTH-1:0]       rd_data_o,
    input  logic                   rd_ready_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full, pop, push;

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign rd_valid_o = (count_q != '0);
    assign pop        = rd_valid_o & rd_ready_i;
    assign push       = wr_valid_i & (~full | pop);
    assign wr_drop_o  = wr_valid_i & full & ~pop;
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    // At full with a pop, wr_ptr equals rd_ptr: the popped slot is reused as the new tail.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pe_dot_accumulator.sv
// Accumulates signed adder-tree results over a group of steps with saturation, buffers
// completed group sums in an output FIFO and grants issue credits so no group is lost.
module pe_dot_accumulator
    import pe_types::*;
#(
    parameter int DOT_OUTPUT_WIDTH = 24,
    parameter int ACCUM_WIDTH      = 32,
    parameter int TREE_LATENCY     = 4,
    parameter int OUT_DEPTH        = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        i_valid,
    input  logic                        i_first,
    input  logic                        i_last,
    input  logic [DOT_OUTPUT_WIDTH-1:0] i_dot_result,
    output logic                        o_accept,
    output logic                        o_valid,
    output logic [ACCUM_WIDTH-1:0]      o_result,
    output logic                        o_saturated,
    input  logic                        i_ready,
    output logic                        o_error
);

    // Entry width follows ACCUM_WIDTH, so the entry type lives with the parameter.
    typedef struct packed {
        logic                   saturated;
        logic [ACCUM_WIDTH-1:0] sum;
    } pe_accum_entry_t;

    localparam int EW = ACCUM_WIDTH + 1;
    localparam int FW = $clog2(OUT_DEPTH) + 1;
    localparam int CW = $clog2(OUT_DEPTH + TREE_LATENCY + 1) + 1;

    logic [TREE_LATENCY-1:0] dv_q, df_q, dl_q;
    logic                    d_valid, d_first, d_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            dv_q <= '0;
            df_q <= '0;
            dl_q <= '0;
        end else begin
            dv_q <= (dv_q << 1) | TREE_LATENCY'(i_valid);
            df_q <= (df_q << 1) | TREE_LATENCY'(i_first);
            dl_q <= (dl_q << 1) | TREE_LATENCY'(i_last);
        end
    end

    assign d_valid = dv_q[TREE_LATENCY-1];
    assign d_first = df_q[TREE_LATENCY-1];
    assign d_last  = dl_q[TREE_LATENCY-1];

    // Saturating accumulate one bit wider than the accumulator.
    logic [ACCUM_WIDTH-1:0] acc_q, acc_d, clamped;
    logic                   sat_q, sat_d;
    logic [EW-1:0]          dot_ext, acc_ext, sum_ext;
    logic                   ovf;

    assign dot_ext = EW'($signed(i_dot_result));
    assign acc_ext = EW'($signed(acc_q));
    assign sum_ext = acc_ext + dot_ext;
    assign ovf     = sum_ext[EW-1] ^ sum_ext[EW-2];
    assign clamped = !ovf          ? sum_ext[ACCUM_WIDTH-1:0] :
                     sum_ext[EW-1] ? {1'b1, {(ACCUM_WIDTH-1){1'b0}}} :
                                     {1'b0, {(ACCUM_WIDTH-1){1'b1}}};

    pe_accum_state_e state_q, state_d;
    logic            start_c, add_c, push_c;

    always_ff @(posedge clock) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (d_valid)
            state_d = d_last ? IDLE : ACCUM;
    end

    // An orphan step arriving in IDLE opens a fresh group.
    always_comb begin
        start_c = 1'b0;
        add_c   = 1'b0;
        push_c  = 1'b0;
        if (d_valid) begin
            start_c = (state_q == IDLE) | d_first;
            add_c   = ~start_c;
            push_c  = d_last;
        end
    end

    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (start_c) begin
            acc_d = dot_ext[ACCUM_WIDTH-1:0];
            sat_d = 1'b0;
        end else if (add_c) begin
            acc_d = clamped;
            sat_d = sat_q | ovf;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    pe_accum_entry_t wr_entry, rd_entry;
    logic [FW-1:0]   fifo_count;
    logic            fifo_drop;

    assign wr_entry = '{saturated: sat_d, sum: acc_d};

    pe_sync_fifo #(
        .WIDTH ($bits(pe_accum_entry_t)),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .wr_valid_i (push_c),
        .wr_data_i  (wr_entry),
        .wr_drop_o  (fifo_drop),
        .rd_valid_o (o_valid),
        .rd_data_o  (rd_entry),
        .rd_ready_i (i_ready),
        .count_o    (fifo_count)
    );

    assign o_result    = rd_entry.sum;
    assign o_saturated = rd_entry.saturated;

    // Credits: buffered groups plus group ends still travelling through the tree.
    logic [CW-1:0] inflight_c, occupancy_c;

    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < TREE_LATENCY; i++)
            inflight_c = inflight_c + CW'(dv_q[i] & dl_q[i]);
    end

    assign occupancy_c = CW'(fifo_count) + inflight_c + CW'(i_valid & i_last);
    assign o_accept    = (occupancy_c < CW'(OUT_DEPTH));

    logic err_q;

    always_ff @(posedge clock) begin
        if (reset)
            err_q <= 1'b0;
        else if (fifo_drop)
            err_q <= 1'b1;
    end

    assign o_error = err_q;

endmodule

// File: tb/tb_pe_dot_accumulator.sv
// Bench for pe_dot_accumulator: default instance plus a 25-bit accumulator instance on shared stimulus.
module tb_pe_dot_accumulator;

    localparam int TL = 4;
    localparam int DW = 24;

    logic          clock = 1'b0, reset = 1'b1;
    logic          i_valid = 1'b0, i_first = 1'b0, i_last = 1'b0, i_ready = 1'b0;
    logic [DW-1:0] cur_dot = '0;
    logic [DW-1:0] dot_pipe [TL];
    logic [DW-1:0] i_dot_result;

    logic          o_accept, o_valid, o_saturated, o_error;
    logic [31:0]   o_result;
    logic          b_accept, b_valid, b_saturated, b_error;
    logic [24:0]   b_result;

    int n_chk = 0, n_pass = 0;

    bit            pop_s, sat_s, satb_s, acc_pre_s, issued_s;
    logic [31:0]   res_s;
    logic [24:0]   resb_s;

    pe_dot_accumulator dut (
        .clock(clock), .reset(reset), .i_valid(i_valid), .i_first(i_first), .i_last(i_last),
        .i_dot_result(i_dot_result), .o_accept(o_accept), .o_valid(o_valid), .o_result(o_result),
        .o_saturated(o_saturated), .i_ready(i_ready), .o_error(o_error)
    );

    pe_dot_accumulator #(.ACCUM_WIDTH(25)) dut_b (
        .clock(clock), .reset(reset), .i_valid(i_valid), .i_first(i_first), .i_last(i_last),
        .i_dot_result(i_dot_result), .o_accept(b_accept), .o_valid(b_valid), .o_result(b_result),
        .o_saturated(b_saturated), .i_ready(i_ready), .o_error(b_error)
    );

    always #5 clock = ~clock;

    // Stand-in for the adder tree: the dot issued with i_valid shows up TL cycles later.
    always @(posedge clock) begin
        dot_pipe[0] <= cur_dot;
        for (int i = 1; i < TL; i++)
            dot_pipe[i] <= dot_pipe[i-1];
    end
    assign i_dot_result = dot_pipe[TL-1];

    function automatic logic [DW-1:0] d24(input longint x);
        return x[DW-1:0];
    endfunction

    // Group sum from the arithmetic rules: clamp to the w-bit signed range after every add.
    function automatic longint model(input longint dots[$], input int w, output bit sat);
        longint hi  = (longint'(1) <<< (w - 1)) - 1;
        longint lo  = -(longint'(1) <<< (w - 1));
        longint acc = dots[0];
        sat = 1'b0;
        for (int i = 1; i < dots.size(); i++) begin
            acc += dots[i];
            if (acc > hi) begin acc = hi; sat = 1'b1; end
            else if (acc < lo) begin acc = lo; sat = 1'b1; end
        end
        return acc;
    endfunction

    // One cycle: credit sampled before i_valid is driven; a gated last stalls without credit.
    task automatic cyc(input bit v, input bit f, input bit l, input logic [DW-1:0] d,
                       input bit rdy, input bit gate);
        @(negedge clock);
        i_valid = 1'b0; i_first = f; i_last = l; i_ready = rdy; cur_dot = '0;
        #1;
        acc_pre_s = o_accept;
        issued_s  = v && (!gate || !l || acc_pre_s);
        i_valid   = issued_s;
        cur_dot   = issued_s ? d : '0;
        #1;
        pop_s  = o_valid && i_ready;
        res_s  = o_result;
        sat_s  = o_saturated;
        resb_s = b_result;
        satb_s = b_saturated;
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, 1'b0, 1'b0, '0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0; cur_dot = '0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_chk++; if (o_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", o_valid); else n_pass++;
        n_chk++; if (o_result !== 32'd0) $display("FAIL reset_result got=%h exp=0", o_result); else n_pass++;
        n_chk++; if (o_saturated !== 1'b0) $display("FAIL reset_sat got=%b exp=0", o_saturated); else n_pass++;
        n_chk++; if (o_error !== 1'b0) $display("FAIL reset_error got=%b exp=0", o_error); else n_pass++;
        n_chk++; if (o_accept !== 1'b1) $display("FAIL reset_accept got=%b exp=1", o_accept); else n_pass++;
    endtask

    task automatic test_group3();
        longint dq[$] = '{10, -3, 5};
        bit s; longint e = model(dq, 32, s);
        int first = -1, pops = 0;
        logic [31:0] got = '0; bit gots = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, d24(10), 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, d24(-3), 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, d24(5),  1'b1, 1'b0);
        for (int n = 3; n < 16; n++) begin
            idle(1'b1);
            if (pop_s) begin
                if (pops == 0) begin first = n; got = res_s; gots = sat_s; end
                pops++;
            end
        end
        n_chk++; if (first != 2 + TL + 1) $display("FAIL g3_latency got=%0d exp=%0d", first, 2 + TL + 1); else n_pass++;
        n_chk++; if (got !== 32'(e)) $display("FAIL g3_result got=%0d exp=%0d", $signed(got), e); else n_pass++;
        n_chk++; if (gots !== s) $display("FAIL g3_sat got=%b exp=%b", gots, s); else n_pass++;
        n_chk++; if (pops != 1) $display("FAIL g3_count got=%0d exp=1", pops); else n_pass++;
    endtask

    task automatic test_single();
        int pops = 0;
        logic [31:0] got [2];
        got[0] = '0; got[1] = '0;
        cyc(1'b1, 1'b1, 1'b1, d24(-7), 1'b1, 1'b0);
        for (int n = 0; n < 10; n++) begin
            idle(1'b1);
            if (pop_s) begin if (pops < 2) got[pops] = res_s; pops++; end
        end
        // Last without first must open a group on its own.
        cyc(1'b1, 1'b0, 1'b1, d24(3), 1'b1, 1'b0);
        for (int n = 0; n < 10; n++) begin
            idle(1'b1);
            if (pop_s) begin if (pops < 2) got[pops] = res_s; pops++; end
        end
        n_chk++; if (got[0] !== 32'hFFFF_FFF9) $display("FAIL single_result got=%h exp=fffffff9", got[0]); else n_pass++;
        n_chk++; if (got[1] !== 32'd3) $display("FAIL orphan_last got=%0d exp=3", got[1]); else n_pass++;
        n_chk++; if (pops != 2) $display("FAIL single_count got=%0d exp=2", pops); else n_pass++;
    endtask

    task automatic test_saturate();
        longint g1[$] = '{longint'(24'h7FFFFF), longint'(24'h7FFFFF), longint'(24'h7FFFFF)};
        longint g2[$] = '{1};
        longint ea[2], eb[2]; bit sa[2], sb[2];
        int pops = 0;
        ea[0] = model(g1, 32, sa[0]); eb[0] = model(g1, 25, sb[0]);
        ea[1] = model(g2, 32, sa[1]); eb[1] = model(g2, 25, sb[1]);
        cyc(1'b1, 1'b1, 1'b0, 24'h7FFFFF, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 24'h7FFFFF, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 24'h7FFFFF, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, d24(1), 1'b1, 1'b0);
        for (int n = 0; n < 14; n++) begin
            idle(1'b1);
            if (pop_s && pops < 2) begin
                n_chk++; if (resb_s !== 25'(eb[pops]) || satb_s !== sb[pops])
                    $display("FAIL sat25_g%0d got=%h/%b exp=%h/%b", pops, resb_s, satb_s, 25'(eb[pops]), sb[pops]);
                else n_pass++;
                n_chk++; if (res_s !== 32'(ea[pops]) || sat_s !== sa[pops])
                    $display("FAIL sat32_g%0d got=%h/%b exp=%h/%b", pops, res_s, sat_s, 32'(ea[pops]), sa[pops]);
                else n_pass++;
                pops++;
            end else if (pop_s) pops++;
        end
        n_chk++; if (pops != 2) $display("FAIL sat_count got=%0d exp=2", pops); else n_pass++;
    endtask

    task automatic test_backpressure();
        int issued = 0, pops = 0;
        logic [31:0] vals[$];
        for (int n = 0; n < 10; n++) begin
            cyc(1'b1, 1'b1, 1'b1, d24(issued + 1), 1'b0, 1'b1);
            if (issued_s) issued++;
        end
        n_chk++; if (issued != 4) $display("FAIL bp_issued got=%0d exp=4", issued); else n_pass++;
        n_chk++; if (acc_pre_s !== 1'b0) $display("FAIL bp_accept_low got=%b exp=0", acc_pre_s); else n_pass++;
        n_chk++; if (o_valid !== 1'b1 || o_result !== 32'd1)
            $display("FAIL bp_head got=%b/%0d exp=1/1", o_valid, o_result); else n_pass++;
        for (int n = 0; n < 10; n++) begin
            idle(1'b1);
            if (pop_s) begin vals.push_back(res_s); pops++; end
        end
        n_chk++; if (pops != 4) $display("FAIL bp_pops got=%0d exp=4", pops); else n_pass++;
        for (int i = 0; i < 4 && i < vals.size(); i++) begin
            n_chk++; if (vals[i] !== 32'(i + 1)) $display("FAIL bp_order%0d got=%0d exp=%0d", i, vals[i], i + 1); else n_pass++;
        end
        n_chk++; if (acc_pre_s !== 1'b1) $display("FAIL bp_accept_back got=%b exp=1", acc_pre_s); else n_pass++;
        n_chk++; if (o_error !== 1'b0) $display("FAIL bp_error got=%b exp=0", o_error); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int pops = 0;
        logic [31:0] got = '0;
        cyc(1'b1, 1'b1, 1'b0, d24(5), 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, d24(6), 1'b1, 1'b0);
        do_reset();
        for (int n = 0; n < 8; n++) begin idle(1'b1); if (pop_s) pops++; end
        n_chk++; if (pops != 0) $display("FAIL rmid_no_output got=%0d exp=0", pops); else n_pass++;
        cyc(1'b1, 1'b1, 1'b0, d24(4), 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, d24(4), 1'b1, 1'b0);
        for (int n = 0; n < 10; n++) begin
            idle(1'b1);
            if (pop_s) begin got = res_s; pops++; end
        end
        n_chk++; if (pops != 1 || got !== 32'd8) $display("FAIL rmid_next got=%0d/%0d exp=1/8", pops, got); else n_pass++;
    endtask

    task automatic test_overflow();
        int pops = 0;
        logic [31:0] vals[$];
        do_reset();
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'b1, 1'b1, d24(i + 1), 1'b0, (i < 4));
        for (int n = 0; n < 8; n++) idle(1'b0);
        n_chk++; if (o_error !== 1'b1) $display("FAIL ovf_error got=%b exp=1", o_error); else n_pass++;
        for (int n = 0; n < 10; n++) begin
            idle(1'b1);
            if (pop_s) begin vals.push_back(res_s); pops++; end
        end
        n_chk++; if (pops != 4) $display("FAIL ovf_pops got=%0d exp=4", pops); else n_pass++;
        for (int i = 0; i < 4 && i < vals.size(); i++) begin
            n_chk++; if (vals[i] !== 32'(i + 1)) $display("FAIL ovf_order%0d got=%0d exp=%0d", i, vals[i], i + 1); else n_pass++;
        end
        n_chk++; if (o_error !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", o_error); else n_pass++;
        do_reset();
        #1;
        n_chk++; if (o_error !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", o_error); else n_pass++;
    endtask

    task automatic test_random();
        longint exp_a[$], exp_b[$], grp[$];
        bit     esa[$], esb[$];
        int     groups = 0, len = 1, step = 0, bad = 0, pops = 0;
        logic [DW-1:0] d;
        do_reset();
        len = $urandom_range(1, 6);
        for (int n = 0; n < 3000 && (groups < 40 || exp_a.size() > 0); n++) begin
            bit want = (groups < 40) && ($urandom_range(0, 3) != 0);
            bit rdy  = (groups >= 40) || ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       d = 24'h7FFFFF;
                1:       d = 24'h800000;
                default: d = DW'($urandom);
            endcase
            cyc(want, step == 0, step == len - 1, d, rdy, 1'b1);
            if (issued_s) begin
                grp.push_back(longint'($signed(d)));
                step++;
                if (step == len) begin
                    bit s;
                    exp_a.push_back(model(grp, 32, s)); esa.push_back(s);
                    exp_b.push_back(model(grp, 25, s)); esb.push_back(s);
                    grp.delete(); step = 0; groups++; len = $urandom_range(1, 6);
                end
            end
            if (pop_s) begin
                longint ea = 0, eb = 0; bit sa = 0, sb = 0;
                if (exp_a.size() > 0) begin
                    ea = exp_a.pop_front(); sa = esa.pop_front();
                    eb = exp_b.pop_front(); sb = esb.pop_front();
                end
                pops++;
                n_chk++; if (res_s !== 32'(ea) || sat_s !== sa) begin
                    if (bad < 5) $display("FAIL rand32_%0d got=%h/%b exp=%h/%b", pops, res_s, sat_s, 32'(ea), sa);
                    bad++;
                end else n_pass++;
                n_chk++; if (resb_s !== 25'(eb) || satb_s !== sb) begin
                    if (bad < 5) $display("FAIL rand25_%0d got=%h/%b exp=%h/%b", pops, resb_s, satb_s, 25'(eb), sb);
                    bad++;
                end else n_pass++;
            end
        end
        n_chk++; if (exp_a.size() != 0 || groups != 40)
            $display("FAIL rand_drain left=%0d groups=%0d exp=0/40", exp_a.size(), groups); else n_pass++;
        n_chk++; if (o_error !== 1'b0) $display("FAIL rand_error got=%b exp=0", o_error); else n_pass++;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        test_reset();
        test_group3();
        test_single();
        test_saturate();
        test_backpressure();
        test_reset_mid();
        test_overflow();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
